// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing types, line constants and CRC-32 helpers
package eth_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    // reflected CRC-32, LSB of each byte first as it goes on the wire
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ CRC_POLY : r >> 1;
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction
endpackage

// File: rtl/eth_crc.sv
// eth_crc: byte-wide Ethernet CRC-32 with clear, running FCS value and residue check
module eth_crc
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    input  logic [7:0]  d_in,
    output logic [31:0] crc_out,
    output logic        crc_ok
);
    logic [31:0] crc, base, nxt;

    // a byte fed during the clear cycle is folded onto the initial value
    always_comb begin
        base = rst ? 32'hFFFFFFFF : crc;
        nxt = en_in ? crc32_byte(base, d_in) : base;
    end

    always_ff @(posedge clk) crc <= nxt;

    assign crc_out = ~nxt;
    assign crc_ok = bitrev32(crc) == CRC_RESIDUE;
endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: wraps a payload stream with preamble, SFD, pad, FCS and inter-frame gap
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_DATA = 60,
    parameter int MAX_DATA = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done
);
    state_t state;
    logic [10:0] cnt;
    logic [7:0] sc, crc_d;
    logic [31:0] fcs_reg, crc_out;
    logic crc_clr, crc_en, acc;

    assign acc = (state == SFD || state == DATA) && in_valid && in_ready;
    assign crc_en = acc || state == PAD;
    assign crc_d = (state == PAD) ? 8'h00 : in_data;

    eth_crc u_crc (.clk(clk), .rst(crc_clr | rst), .en_in(crc_en), .d_in(crc_d), .crc_out(crc_out), .crc_ok());

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sc <= '0;
            fcs_reg <= '0;
            crc_clr <= 1'b0;
            in_ready <= 1'b0;
            tx_data <= 8'h00;
            tx_en <= 1'b0;
            tx_er <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            crc_clr <= 1'b0;
            tx_er <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    state <= PREAMBLE;
                    busy <= 1'b1;
                    tx_en <= 1'b1;
                    tx_data <= PREAMBLE_BYTE;
                    sc <= 8'd1;
                    cnt <= '0;
                end
                // the first payload byte is taken while the SFD is on the line
                PREAMBLE: if (sc == 8'(PREAMBLE_LEN)) begin
                    state <= SFD;
                    tx_data <= SFD_BYTE;
                    crc_clr <= 1'b1;
                    in_ready <= 1'b1;
                end else sc <= sc + 8'd1;
                SFD, DATA: if (cnt == 11'(MAX_DATA)) begin
                    state <= DRAIN;
                    tx_er <= 1'b1;
                    tx_data <= 8'h00;
                end else if (!in_valid) begin
                    state <= IFG;
                    tx_er <= 1'b1;
                    tx_data <= 8'h00;
                    in_ready <= 1'b0;
                    sc <= 8'd0;
                end else begin
                    tx_data <= in_data;
                    cnt <= cnt + 11'd1;
                    if (in_last) begin
                        in_ready <= 1'b0;
                        sc <= 8'd0;
                        state <= (cnt + 11'd1 < 11'(MIN_DATA)) ? PAD : FCS;
                        if (cnt + 11'd1 >= 11'(MIN_DATA)) fcs_reg <= crc_out;
                    end else if (cnt + 11'd1 == 11'(MAX_DATA)) in_ready <= 1'b0;
                end
                PAD: begin
                    tx_data <= 8'h00;
                    cnt <= cnt + 11'd1;
                    if (cnt + 11'd1 == 11'(MIN_DATA)) begin
                        state <= FCS;
                        fcs_reg <= crc_out;
                    end
                end
                FCS: if (sc == 8'd4) begin
                    state <= IFG;
                    tx_en <= 1'b0;
                    tx_data <= 8'h00;
                    sc <= 8'd1;
                end else begin
                    tx_data <= fcs_reg[{sc[1:0], 3'b000} +: 8];
                    frame_done <= sc == 8'd3;
                    sc <= sc + 8'd1;
                end
                DRAIN: begin
                    tx_en <= 1'b0;
                    in_ready <= !(in_valid && in_ready && in_last);
                    if (in_valid && in_ready && in_last) begin
                        state <= IFG;
                        sc <= 8'd1;
                    end
                end
                IFG: begin
                    tx_en <= 1'b0;
                    tx_data <= 8'h00;
                    if (sc == 8'(IFG_LEN - 1)) begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end else sc <= sc + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: scoreboard bench comparing the framer's line stream to a frame-level model
module tb_eth_tx_framer;
    import eth_pkg::*;

    typedef struct {
        int len;
        int cut;
        int en_cycles;
        int done;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic in_ready, tx_en, tx_er, busy, frame_done;
    logic [7:0] tx_data;
    logic chk_clr, chk_en, chk_ok;
    logic [31:0] chk_crc;
    int pos = 0;
    int checks = 0, errors = 0;
    logic [7:0] pl [0:1599];
    logic [9:0] exp_q [$];
    int exp_len [$];
    bit exp_good [$];
    logic [9:0] cap [$];
    int frames = 0, last_len = 0, last_done = 0, idle = 0, drain_acc = 0;
    bit seen = 1'b0, gap_chk = 1'b0;

    always #5 clk = ~clk;

    eth_tx_framer dut (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
                       .in_ready(in_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
                       .busy(busy), .frame_done(frame_done));

    eth_crc chk (.clk(clk), .rst(chk_clr), .en_in(chk_en), .d_in(tx_data), .crc_out(chk_crc), .crc_ok(chk_ok));

    assign chk_clr = tx_en && pos == 7;
    assign chk_en = tx_en && !tx_er && pos >= 8;
    always_ff @(posedge clk) pos <= tx_en ? pos + 1 : 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
    endtask

    // line image of one frame: {frame_done, tx_er, tx_data} per tx_en cycle
    function automatic void expect_frame(input int len, input int cut);
        logic [7:0] body [$];
        logic [31:0] c;
        int k;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        if (cut >= 0 || len > 1514) begin
            k = (cut >= 0) ? cut : 1514;
            for (int i = 0; i < k; i++) exp_q.push_back({2'b00, pl[i]});
            exp_q.push_back(10'h100);
            exp_len.push_back(8 + k + 1);
            exp_good.push_back(1'b0);
            return;
        end
        for (int i = 0; i < len; i++) body.push_back(pl[i]);
        while (body.size() < 60) body.push_back(8'h00);
        foreach (body[i]) begin
            exp_q.push_back({2'b00, body[i]});
            for (int j = 0; j < 8; j++) c = {1'b0, c[31:1]} ^ ({32{c[0] ^ body[i][j]}} & 32'hEDB88320);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) exp_q.push_back({j == 3, 1'b0, c[8*j +: 8]});
        exp_len.push_back(8 + body.size() + 4);
        exp_good.push_back(1'b1);
    endfunction

    task automatic end_frame();
        int n, mism;
        bit good;
        logic [9:0] e, m;
        if (exp_len.size() == 0) begin
            check("frame_unexpected", cap.size(), 0);
            return;
        end
        n = exp_len.pop_front();
        good = exp_good.pop_front();
        mism = 0;
        last_done = 0;
        check("frame_len", cap.size(), n);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            m = e[8] ? 10'h300 : 10'h3FF;
            if (i < cap.size() && ((cap[i] ^ e) & m) != 10'h000) begin
                if (mism == 0) $display("first diff at byte %0d got %h want %h", i, cap[i], e);
                mism++;
            end
        end
        foreach (cap[i]) if (cap[i][9]) last_done++;
        check("frame_bytes", mism, 0);
        if (good) check("fcs_residue", chk_ok, 1);
        last_len = cap.size();
        frames++;
        seen = 1'b1;
        idle = 0;
        cap.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cap.delete();
            seen = 1'b0;
            idle = 0;
        end else if (tx_en) begin
            if (cap.size() == 0 && seen) begin
                check("ifg_min", 32'(idle >= 12), 1);
                if (gap_chk) check("ifg_exact", idle, 12);
            end
            cap.push_back({frame_done, tx_er, tx_data});
        end else begin
            if (in_valid && in_ready) drain_acc++;
            if (cap.size() > 0) end_frame();
            idle++;
        end
    end

    task automatic send(input int len, input int cut, output int got);
        int t;
        bit a;
        got = 0;
        t = 0;
        while (got < len && t < 20000) begin
            if (got == cut) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                @(posedge clk);
                #1;
                break;
            end
            in_valid = 1'b1;
            in_data = pl[got];
            in_last = (got == len - 1);
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) got++;
            t++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (t >= 20000) check("send_timeout", got, len);
    endtask

    task automatic wait_frame(input int n);
        int t;
        t = 0;
        while (frames < n && t < 40000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (frames < n) check("frame_wait", frames, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_en"}, tx_en, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_er"}, tx_er, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        vec_t tv [5];
        int got, f0, len, t;
        tv[0] = '{14, -1, 72, 1};
        tv[1] = '{100, -1, 112, 1};
        tv[2] = '{60, -1, 72, 1};
        tv[3] = '{59, -1, 72, 1};
        tv[4] = '{40, 20, 29, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;

        foreach (tv[k]) begin
            fill(tv[k].len);
            expect_frame(tv[k].len, tv[k].cut);
            f0 = frames;
            send(tv[k].len, tv[k].cut, got);
            wait_frame(f0 + 1);
            check($sformatf("tv%0d_en_cycles", k), last_len, tv[k].en_cycles);
            check($sformatf("tv%0d_frame_done", k), last_done, tv[k].done);
            repeat (15) @(posedge clk);
            #1;
        end

        fill(1600);
        expect_frame(1600, -1);
        f0 = frames;
        drain_acc = 0;
        send(1600, -1, got);
        check("ovf_accepted", got, 1600);
        wait_frame(f0 + 1);
        check("ovf_en_cycles", last_len, 1523);
        check("ovf_frame_done", last_done, 0);
        check("drain_bytes", drain_acc, 86);
        repeat (15) @(posedge clk);
        #1;

        fill(40);
        expect_frame(40, 20);
        f0 = frames;
        send(40, 20, got);
        gap_chk = 1'b1;
        for (int r = 0; r < 3; r++) begin
            len = (r == 1) ? 100 : 30 + r;
            fill(len);
            expect_frame(len, -1);
            send(len, -1, got);
        end
        wait_frame(f0 + 4);
        gap_chk = 1'b0;
        check("b2b_last_done", last_done, 1);
        repeat (15) @(posedge clk);
        #1;

        fill(50);
        in_valid = 1'b1;
        in_data = pl[0];
        t = 0;
        while (!tx_en && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (!tx_en) check("preamble_start", tx_en, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fill(50);
        expect_frame(50, -1);
        f0 = frames;
        send(50, -1, got);
        wait_frame(f0 + 1);
        check("post_rst_en_cycles", last_len, 72);

        f0 = frames;
        for (int r = 0; r < 25; r++) begin
            len = (r % 8 == 7) ? $urandom_range(1000, 1514) : $urandom_range(1, 200);
            fill(len);
            expect_frame(len, -1);
            send(len, -1, got);
            repeat ($urandom_range(0, 20)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_frame(f0 + 25);
        repeat (20) @(posedge clk);
        #1;
        check("exp_left", exp_len.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
